// File: rtl/fft_harm_sched.sv
// ---------------------------------------------------------------------------
// fft_harm_sched
//
// Frame scheduler for the FFT harmonic-measurement path. An accepted start
// gates exactly one FFT_LEN-sample frame from the ADC stream into the FFT
// sink (sop on beat 0, eop on beat FFT_LEN-1). It then waits for the FFT
// output frame and captures the magnitudes at bins base, 2*base, ...,
// N_HARM*base into harm_data. A done pulse follows the output eop by one
// cycle.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           1-cycle request, honoured only while busy=0
//   base_bin        fundamental bin, latched on an accepted start
//   adc_valid       ADC sample present this cycle
//   fft_sink_ready  FFT core accepts an input beat
//   fft_sink_valid  input beat valid (adc_valid while in FEED)
//   fft_sink_sop    first beat of the input frame (qualified by valid)
//   fft_sink_eop    last beat of the input frame (qualified by valid)
//   src_valid/sop/eop, amp   FFT output stream and magnitude
//   harm_data       slot k (bits k*DW +: DW) = magnitude at bin base*(k+1)
//   busy            FSM not idle
//   done            1-cycle pulse, harm_data valid
//   err             sticky error (base 0 or output timeout)
//   state_dbg       current FSM state encoding
//
// Handshake: a sink beat transfers on a rising edge where fft_sink_valid and
// fft_sink_ready are both high; valid never depends on ready. The output
// stream has no backpressure: a src beat is taken whenever src_valid is high.
// ---------------------------------------------------------------------------
module fft_harm_sched #(
    parameter int FFT_LEN = 256,
    parameter int DW      = 24,
    parameter int N_HARM  = 5,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     base_bin,
    input  logic                 adc_valid,
    input  logic                 fft_sink_ready,
    output logic                 fft_sink_valid,
    output logic                 fft_sink_sop,
    output logic                 fft_sink_eop,
    input  logic                 src_valid,
    input  logic                 src_sop,
    input  logic                 src_eop,
    input  logic [DW-1:0]        amp,
    output logic [N_HARM*DW-1:0] harm_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           state_dbg
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int K_W    = $clog2(N_HARM + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_WAIT  = 3'd2,
        S_CATCH = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  in_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0]  out_cnt_q;
    logic [CNT_W:0]    target_q;
    logic [CNT_W-1:0]  base_q;
    logic [K_W-1:0]    k_q;
    logic [DW-1:0]     slot_q [N_HARM];
    logic              err_q;

    logic              start_ok;
    logic              start_bad;
    logic              in_beat;
    logic              last_in;
    logic              timeout_hit;
    logic              src_first;
    logic              src_beat;
    logic [CNT_W-1:0]  beat_idx;
    logic              capture_hit;

    // A start with base 0 cannot name a fundamental; it only flags err.
    assign start_ok  = start && (state_q == S_IDLE) && (base_bin != '0);
    assign start_bad = start && (state_q == S_IDLE) && (base_bin == '0);

    assign in_beat     = fft_sink_valid && fft_sink_ready;
    assign last_in     = (in_cnt_q == CNT_W'(FFT_LEN - 1));
    assign timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    // The sop beat that ends WAIT is itself output bin 0.
    assign src_first = (state_q == S_WAIT) && src_valid && src_sop;
    assign src_beat  = src_first || ((state_q == S_CATCH) && src_valid);
    assign beat_idx  = (state_q == S_WAIT) ? '0 : out_cnt_q;

    // target is one bit wider than a bin index, so once it passes the
    // last bin it can never match again and later slots stay zero.
    assign capture_hit = src_beat
                      && ({1'b0, beat_idx} == target_q)
                      && (k_q < K_W'(N_HARM));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_FEED;
            end
            S_FEED: begin
                if (in_beat && last_in) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A single-beat output frame (sop and eop together) ends at once.
                if (src_first) begin
                    state_d = src_eop ? S_DONE : S_CATCH;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_CATCH: begin
                if (src_valid && src_eop) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        fft_sink_valid = adc_valid && (state_q == S_FEED);
        fft_sink_sop   = fft_sink_valid && (in_cnt_q == '0);
        fft_sink_eop   = fft_sink_valid && last_in;
    end

    assign state_dbg = state_q;
    assign err       = err_q;

    // ------------------------------------------------------------------
    // Counters, capture bookkeeping and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q   <= '0;
            wait_cnt_q <= '0;
            out_cnt_q  <= '0;
            target_q   <= '0;
            base_q     <= '0;
            k_q        <= '0;
            err_q      <= 1'b0;
        end else if (start_ok) begin
            in_cnt_q   <= '0;
            wait_cnt_q <= '0;
            out_cnt_q  <= '0;
            target_q   <= {1'b0, base_bin};
            base_q     <= base_bin;
            k_q        <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start_bad) begin
                err_q <= 1'b1;
            end
            // FFT_LEN is a power of two, so the index wraps to 0 after eop.
            if (in_beat) begin
                in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
            if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                if (timeout_hit && !src_first) begin
                    err_q <= 1'b1;
                end
            end
            if (src_beat) begin
                out_cnt_q <= beat_idx + CNT_W'(1);
            end
            if (capture_hit) begin
                target_q <= target_q + {1'b0, base_q};
                k_q      <= k_q + K_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Harmonic slots
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_HARM; i++) begin
                slot_q[i] <= '0;
            end
        end else if (start_ok) begin
            for (int i = 0; i < N_HARM; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_HARM; i++) begin
                if (capture_hit && (k_q == K_W'(i))) begin
                    slot_q[i] <= amp;
                end
            end
        end
    end

    always_comb begin
        harm_data = '0;
        for (int i = 0; i < N_HARM; i++) begin
            harm_data[i*DW +: DW] = slot_q[i];
        end
    end

endmodule
